cp0_commit_ctrl: RTL

- Commit-stage sequencer in front of the CP0 register file.
- Arbitrates interrupt, exception, ERET and TLB-instruction events arriving from WB, and issues one-cycle side-effect pulses to CP0/TLB.
- Owns the pipeline flush/redirect handshake, and stalls WB while a multi-cycle TLB op completes and the pipeline refetches.

---
 rtl/cp0_commit_ctrl_pkg.sv | 40 ++++
 rtl/cp0_commit_ctrl_if.sv | 45 ++++
 rtl/cp0_commit_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cp0_commit_ctrl_pkg.sv
// Shared types and constants for the CP0 commit sequencer: FSM states, ExcCodes,
// TLB-op bit positions, exception vector offsets and the vector/one-hot helpers.
package cp0_commit_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TLB_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } commit_state_t;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_TLBL = 5'd2;
  localparam logic [4:0] EXCCODE_TLBS = 5'd3;

  // Bit positions inside the one-hot {TLBWI,TLBR,TLBP} field.
  localparam int TLBOP_TLBP  = 0;
  localparam int TLBOP_TLBR  = 1;
  localparam int TLBOP_TLBWI = 2;

  localparam logic [31:0] EXC_OFF_REFILL = 32'h0000_0000;
  localparam logic [31:0] EXC_OFF_GEN    = 32'h0000_0180;

  // The refill vector is only used for a first-level TLB miss; nested misses go general.
  function automatic logic [31:0] exc_offset(input logic refill, input logic [4:0] code,
                                             input logic exl);
    if (refill && (code == EXCCODE_TLBL || code == EXCCODE_TLBS) && !exl)
      return EXC_OFF_REFILL;
    return EXC_OFF_GEN;
  endfunction

  function automatic logic [2:0] tlbop_onehot(input logic [2:0] op);
    logic [2:0] r;
    r = '0;
    if (op[TLBOP_TLBWI])     r[TLBOP_TLBWI] = 1'b1;
    else if (op[TLBOP_TLBR]) r[TLBOP_TLBR]  = 1'b1;
    else if (op[TLBOP_TLBP]) r[TLBOP_TLBP]  = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/cp0_commit_ctrl_if.sv
// Commit bus between WB/CP0/fetch and the commit sequencer.
// slave = the sequencer side, master = the pipeline/CP0/fetch side.
interface cp0_commit_ctrl_if;

  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_pc;
  logic        wb_ex;
  logic [4:0]  wb_exccode;
  logic        wb_refill;
  logic        wb_bd;
  logic [31:0] wb_badvaddr;
  logic        wb_eret;
  logic [2:0]  wb_tlb_op;
  logic        int_pending;
  logic        status_exl;
  logic        status_bev;
  logic [31:0] epc;
  logic        c0_ex;
  logic [4:0]  c0_exccode;
  logic        c0_bd;
  logic [31:0] c0_badvaddr;
  logic [31:0] c0_pc;
  logic        c0_eret;
  logic [2:0]  c0_tlb_op;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport slave (
    input  wb_valid, wb_pc, wb_ex, wb_exccode, wb_refill, wb_bd, wb_badvaddr,
           wb_eret, wb_tlb_op, int_pending, status_exl, status_bev, epc, redirect_ready,
    output wb_ready, c0_ex, c0_exccode, c0_bd, c0_badvaddr, c0_pc, c0_eret, c0_tlb_op,
           flush, redirect_valid, redirect_pc
  );

  modport master (
    output wb_valid, wb_pc, wb_ex, wb_exccode, wb_refill, wb_bd, wb_badvaddr,
           wb_eret, wb_tlb_op, int_pending, status_exl, status_bev, epc, redirect_ready,
    input  wb_ready, c0_ex, c0_exccode, c0_bd, c0_badvaddr, c0_pc, c0_eret, c0_tlb_op,
           flush, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/cp0_commit_ctrl.sv
// Commit-stage sequencer: arbitrates INT/exception/ERET/TLB events, pulses CP0 and owns flush/redirect.
// Define CP0_PERF_CNT_EN to add the perf_exc/perf_int/perf_tlb event counters.
module cp0_commit_ctrl
  import cp0_commit_ctrl_pkg::*;
#(
  parameter int unsigned TLB_LAT      = 2,
  parameter logic [31:0] EXC_BASE     = 32'h8000_0000,
  parameter logic [31:0] EXC_BASE_BEV = 32'hBFC0_0200
) (
  input  logic              clk,
  input  logic              reset,
  cp0_commit_ctrl_if.slave  bus
`ifdef CP0_PERF_CNT_EN
  ,
  output logic [31:0]       perf_exc,
  output logic [31:0]       perf_int,
  output logic [31:0]       perf_tlb
`endif
);

  localparam logic [2:0] TLB_CNT_INIT = 3'(TLB_LAT - 1);

  commit_state_t state_q;
  logic [2:0]    tlb_cnt_q;
  logic          redirect_valid_q;
  logic [31:0]   redirect_pc_q;

  logic          take_int, take_exc, take_eret, take_tlb, tlb_done;
  logic [4:0]    exc_code;
  logic [31:0]   exc_vector_d;
  logic [31:0]   refetch_pc_d;

  // Commit decisions must answer WB in the same cycle, so the pulses are decoded combinationally.
  always_comb begin
    take_int  = 1'b0;
    take_exc  = 1'b0;
    take_eret = 1'b0;
    take_tlb  = 1'b0;
    if (state_q == ST_IDLE && bus.wb_valid) begin
      if (bus.int_pending && !bus.status_exl) take_int  = 1'b1;
      else if (bus.wb_ex)                     take_exc  = 1'b1;
      else if (bus.wb_eret)                   take_eret = 1'b1;
      else if (|bus.wb_tlb_op)                take_tlb  = 1'b1;
    end
    tlb_done     = (state_q == ST_TLB_WAIT) && (tlb_cnt_q == 3'd0);
    exc_code     = take_int ? EXCCODE_INT : bus.wb_exccode;
    exc_vector_d = (bus.status_bev ? EXC_BASE_BEV : EXC_BASE)
                 + exc_offset(bus.wb_refill, exc_code, bus.status_exl);
    refetch_pc_d = bus.wb_pc + 32'd4;
  end

  assign bus.wb_ready       = ((state_q == ST_IDLE) && !take_tlb) || tlb_done;
  assign bus.flush          = take_int || take_exc || take_eret || tlb_done;
  assign bus.c0_ex          = take_int || take_exc;
  assign bus.c0_exccode     = bus.c0_ex ? exc_code : 5'd0;
  assign bus.c0_bd          = bus.c0_ex ? bus.wb_bd : 1'b0;
  assign bus.c0_badvaddr    = bus.c0_ex ? bus.wb_badvaddr : 32'd0;
  assign bus.c0_pc          = bus.c0_ex ? bus.wb_pc : 32'd0;
  assign bus.c0_eret        = take_eret;
  assign bus.c0_tlb_op      = take_tlb ? tlbop_onehot(bus.wb_tlb_op) : 3'd0;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      tlb_cnt_q        <= 3'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take_int || take_exc) begin
            state_q          <= ST_REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= exc_vector_d;
          end else if (take_eret) begin
            state_q          <= ST_REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= bus.epc;
          end else if (take_tlb) begin
            state_q   <= ST_TLB_WAIT;
            tlb_cnt_q <= TLB_CNT_INIT;
          end
        end
        ST_TLB_WAIT: begin
          // Refetch the next instruction so it is translated under the updated TLB.
          if (tlb_done) begin
            state_q          <= ST_REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= refetch_pc_d;
          end else begin
            tlb_cnt_q <= tlb_cnt_q - 3'd1;
          end
        end
        ST_REDIRECT: begin
          if (bus.redirect_ready) begin
            state_q          <= ST_IDLE;
            redirect_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CP0_PERF_CNT_EN
  logic [31:0] perf_exc_q, perf_int_q, perf_tlb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_exc_q <= 32'd0;
      perf_int_q <= 32'd0;
      perf_tlb_q <= 32'd0;
    end else begin
      if (take_exc) perf_exc_q <= perf_exc_q + 32'd1;
      if (take_int) perf_int_q <= perf_int_q + 32'd1;
      if (take_tlb) perf_tlb_q <= perf_tlb_q + 32'd1;
    end
  end

  assign perf_exc = perf_exc_q;
  assign perf_int = perf_int_q;
  assign perf_tlb = perf_tlb_q;
`endif

endmodule
